jpeg_stream_sched: RTL and testbench
====================================

# jpeg_stream_sched

Frame-level scheduler that assembles the final JPEG byte stream. It sequences three sources onto one 8-bit, ready/valid output: a header byte ROM, the entropy-coded 32-bit words produced by the bit concatenator, and the EOI marker. It buffers concatenator words, which arrive without backpressure, in a small FIFO. It serialises those words MSB-first with JPEG 0xFF→0xFF 0x00 byte stuffing.

## Interface
Parameters:
- HDR_LEN, 623: number of header bytes in ROM (legal range 1..1023).
- FIFO_DEPTH, 8: scan-word FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- start  in  1  pulse: begin a frame (honoured only when idle)
- hdr_rd  out  1  header ROM read strobe
- hdr_addr  out  10  header ROM address
- hdr_data  in  8  ROM data, valid the cycle after hdr_rd
- word_data  in  32  scan word, left-aligned, MSB byte first
- word_valid  in  1  scan word strobe (no backpressure)
- word_last  in  1  marks final scan word of frame, with word_valid
- word_bytes  in  2  valid bytes in last word: 1,2,3; 0 means 4
- out_byte  out  8  stream byte
- out_valid  out  1  out_byte valid
- out_ready  in  1  downstream accept
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after EOI 0xD9 accepted
- overflow  out  1  sticky: scan word dropped, FIFO full

## Operation
- FSM states: IDLE, HDR, SCAN, STUFF, EOI_FF, EOI_D9, FIN.
- IDLE: start=1 clears overflow and moves to HDR. Header counter resets to 0.
- HDR: assert hdr_rd with hdr_addr=counter when the output register is empty or being accepted and no read is outstanding. Load hdr_data into the output register on the following cycle. After byte HDR_LEN-1 is loaded, go to SCAN.
- SCAN: pop one FIFO word into the serialiser when the serialiser is empty. Present bytes [31:24],[23:16],[15:8],[7:0] in order, one per output slot.
  - For a word flagged last, present only word_bytes bytes.
  - Any emitted 0xFF byte is followed by STUFF, which emits 0x00, then returns to SCAN.
- After the last valid byte of the last word (including its stuff byte), go to EOI_FF and emit 0xFF. Then go to EOI_D9 and emit 0xD9. No stuffing is applied to the marker.
- FIN: pulse done for one cycle, then go to IDLE.
- FIFO: each word is stored with its last flag and byte count. It accepts words in every state, including IDLE and HDR, because the concatenator may run ahead.
  - Push while full with a pop in the same cycle is accepted.
  - Push while full without a pop drops the word and sets overflow. overflow stays set until the next honoured start.
  - Words received after a frame's last word remain queued for the next frame.
- busy = (state != IDLE).
- start while busy is ignored.

## Timing
- Reset values: out_valid=0, out_byte=0x00, hdr_rd=0, hdr_addr=0, busy=0, done=0, overflow=0. FIFO empty, state IDLE.
- nrst mid-frame discards the FIFO, the serialiser and the pending output byte immediately.
- Output register rules:
  - out_byte is held stable while out_valid=1 and out_ready=0.
  - A byte transfers on the cycle where both are 1.
  - A new byte may load in the same cycle as the transfer.
- start sampled at edge T: busy=1 and first hdr_rd at T+1, first out_valid at T+2.
- Header throughput: one byte per 2 cycles (read latency not overlapped).
- Scan/marker throughput: one byte per cycle with out_ready held high, including across word boundaries. The next word is popped in the same cycle the final byte of the current word loads.
- Empty FIFO in SCAN: out_valid drops to 0 after the pending byte is accepted. There is no bubble byte.
- done is asserted the cycle after 0xD9 transfers. busy falls in the same cycle as done falls.

## Test plan
- HDR_LEN=4, ROM {FF,D8,FF,DB}. Start, then one last word 0x12345678 with bytes=0, out_ready=1 → stream FF D8 FF DB 12 34 56 78 FF D9, then done pulse.
- Scan word 0xAAFFBBFF, last, bytes=0 → AA FF 00 BB FF 00 FF D9. The final 0xFF is stuffed before EOI.
- Last word 0xC1C2C3C4 with word_bytes=2 → C1 C2 FF D9. C3/C4 are not emitted.
- Toggle out_ready pseudo-randomly throughout a frame → byte sequence identical to the out_ready=1 case, and out_byte stable whenever stalled.
- FIFO_DEPTH=8: push 10 words during HDR with no pops → overflow=1 and words 9,10 dropped. The next start clears overflow.
- Assert nrst mid-SCAN, then start a fresh frame → all outputs at reset values, and the new frame begins with header byte 0 and no stale scan bytes.

Source files
------------

// File: rtl/jpeg_stream_sched.sv
// Frame scheduler for the JPEG byte stream: header ROM bytes, then the buffered
// scan words serialised MSB-first with 0xFF stuffing, then the EOI marker.
module jpeg_stream_sched #(
    parameter int HDR_LEN    = 623,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    output logic        hdr_rd,
    output logic [9:0]  hdr_addr,
    input  logic [7:0]  hdr_data,
    input  logic [31:0] word_data,
    input  logic        word_valid,
    input  logic        word_last,
    input  logic [1:0]  word_bytes,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, HDR, SCAN, STUFF, EOI_FF, EOI_D9, FIN} state_t;

    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        rd_pend_q, rd_pend_d;
    logic [7:0]  out_byte_q, out_byte_d;
    logic        out_valid_q, out_valid_d;
    logic        ovf_q, ovf_d;
    logic [31:0] ser_word_q, ser_word_d;
    logic [2:0]  ser_cnt_q, ser_cnt_d;
    logic        ser_last_q, ser_last_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    logic [31:0] mem_word_q  [FIFO_DEPTH];
    logic        mem_last_q  [FIFO_DEPTH];
    logic [1:0]  mem_bytes_q [FIFO_DEPTH];

    logic        fifo_empty, fifo_full, pop, push_ok, can_load, ld;
    logic [7:0]  ld_byte;
    logic [AW-1:0] rd_idx;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_idx     = rd_ptr_q[AW-1:0];
    // A full FIFO still takes a word when the same cycle frees a slot.
    assign push_ok    = word_valid && (!fifo_full || pop);
    assign can_load   = !out_valid_q || out_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_pend_d   = rd_pend_q;
        out_byte_d  = out_byte_q;
        out_valid_d = out_valid_q && !out_ready;
        ovf_d       = ovf_q;
        ser_word_d  = ser_word_q;
        ser_cnt_d   = ser_cnt_q;
        ser_last_d  = ser_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        hdr_rd      = 1'b0;
        done        = 1'b0;
        pop         = 1'b0;
        ld          = 1'b0;
        ld_byte     = 8'h00;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = HDR;
                    cnt_d      = 10'd0;
                    rd_pend_d  = 1'b0;
                    ovf_d      = 1'b0;
                    ser_cnt_d  = 3'd0;
                    ser_last_d = 1'b0;
                end
            end
            HDR: begin
                // The read issued last cycle only happened with room in the
                // output register, so the returning byte always fits.
                if (rd_pend_q) begin
                    ld        = 1'b1;
                    ld_byte   = hdr_data;
                    rd_pend_d = 1'b0;
                    if (cnt_q == 10'(HDR_LEN)) state_d = SCAN;
                end else if (can_load && cnt_q != 10'(HDR_LEN)) begin
                    hdr_rd    = 1'b1;
                    rd_pend_d = 1'b1;
                    cnt_d     = cnt_q + 10'd1;
                end
            end
            SCAN: begin
                if (ser_cnt_q != 3'd0 && can_load) begin
                    ld         = 1'b1;
                    ld_byte    = ser_word_q[31:24];
                    ser_word_d = {ser_word_q[23:0], 8'h00};
                    ser_cnt_d  = ser_cnt_q - 3'd1;
                    if (ser_word_q[31:24] == 8'hFF)
                        state_d = STUFF;
                    else if (ser_cnt_q == 3'd1 && ser_last_q)
                        state_d = EOI_FF;
                end
            end
            STUFF: begin
                if (can_load) begin
                    ld      = 1'b1;
                    ld_byte = 8'h00;
                    state_d = (ser_cnt_q == 3'd0 && ser_last_q) ? EOI_FF : SCAN;
                end
            end
            EOI_FF: begin
                if (can_load) begin
                    ld      = 1'b1;
                    ld_byte = 8'hFF;
                    state_d = EOI_D9;
                end
            end
            EOI_D9: begin
                if (can_load) begin
                    ld      = 1'b1;
                    ld_byte = 8'hD9;
                    state_d = FIN;
                end
            end
            FIN: begin
                // Output register empty here means 0xD9 has been taken.
                if (!out_valid_q) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Refill the serialiser as soon as it drains, even on the cycle its
        // final byte loads, so word boundaries cost no output slot.
        if ((state_q == SCAN || state_q == STUFF) && ser_cnt_d == 3'd0 &&
            !ser_last_q && !fifo_empty) begin
            pop        = 1'b1;
            ser_word_d = mem_word_q[rd_idx];
            ser_last_d = mem_last_q[rd_idx];
            ser_cnt_d  = (mem_last_q[rd_idx] && mem_bytes_q[rd_idx] != 2'd0) ?
                         {1'b0, mem_bytes_q[rd_idx]} : 3'd4;
            rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end

        if (ld) begin
            out_valid_d = 1'b1;
            out_byte_d  = ld_byte;
        end
        if (push_ok) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (word_valid && fifo_full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            cnt_q       <= 10'd0;
            rd_pend_q   <= 1'b0;
            out_byte_q  <= 8'h00;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            ser_word_q  <= 32'd0;
            ser_cnt_q   <= 3'd0;
            ser_last_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_pend_q   <= rd_pend_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            ser_word_q  <= ser_word_d;
            ser_cnt_q   <= ser_cnt_d;
            ser_last_q  <= ser_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_word_q[wr_ptr_q[AW-1:0]]  <= word_data;
            mem_last_q[wr_ptr_q[AW-1:0]]  <= word_last;
            mem_bytes_q[wr_ptr_q[AW-1:0]] <= word_bytes;
        end
    end

    assign hdr_addr  = cnt_q;
    assign out_byte  = out_byte_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_jpeg_stream_sched.sv
// Bench for jpeg_stream_sched: table of single-word frames, leftover/overflow/
// reset sequences, and random frames checked against a queue-based stream model.
module tb_jpeg_stream_sched;
    localparam int HDR_LEN = 4;
    localparam int FD      = 8;

    logic        clk = 1'b0, nrst = 1'b0, start = 1'b0;
    logic        hdr_rd;
    logic [9:0]  hdr_addr;
    logic [7:0]  hdr_data;
    logic [31:0] word_data = 32'd0;
    logic        word_valid = 1'b0, word_last = 1'b0;
    logic [1:0]  word_bytes = 2'd0;
    logic [7:0]  out_byte;
    logic        out_valid, out_ready, busy, done, overflow;

    jpeg_stream_sched #(.HDR_LEN(HDR_LEN), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .nrst(nrst), .start(start), .hdr_rd(hdr_rd), .hdr_addr(hdr_addr),
        .hdr_data(hdr_data), .word_data(word_data), .word_valid(word_valid),
        .word_last(word_last), .word_bytes(word_bytes), .out_byte(out_byte),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
        .overflow(overflow));

    always #5 clk = ~clk;

    logic [7:0] rom [4] = '{8'hFF, 8'hD8, 8'hFF, 8'hDB};
    always @(posedge clk) if (hdr_rd) hdr_data <= rom[hdr_addr[1:0]];

    int checks = 0, errors = 0;
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct { logic [31:0] w; logic last; logic [1:0] nb; } word_t;
    word_t      pq[$], mq[$];
    logic [7:0] eq[$], got[$];
    int         done_cnt = 0;
    int         rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
    bit         stall_prev = 0;
    logic [7:0] stall_byte;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (!nrst) stall_prev = 0;
        else begin
            if (stall_prev) begin
                check("stall_valid_held", out_valid, 1);
                check("stall_byte_held", out_byte, stall_byte);
            end
            if (out_valid && out_ready) got.push_back(out_byte);
            if (done) done_cnt++;
            stall_prev = out_valid && !out_ready;
            stall_byte = out_byte;
        end
    end

    // Expected stream for one frame: header, queued words up to the first last
    // word (trimmed and stuffed), then the unstuffed EOI marker.
    function automatic void model_frame();
        eq.delete();
        for (int i = 0; i < HDR_LEN; i++) eq.push_back(rom[i]);
        while (mq.size() > 0) begin
            word_t x;
            int n;
            x = mq.pop_front();
            n = (x.last && x.nb != 0) ? int'(x.nb) : 4;
            for (int k = 0; k < n; k++) begin
                logic [7:0] b;
                b = x.w[31-8*k -: 8];
                eq.push_back(b);
                if (b == 8'hFF) eq.push_back(8'h00);
            end
            if (x.last) break;
        end
        eq.push_back(8'hFF);
        eq.push_back(8'hD9);
    endfunction

    task automatic begin_frame(input bit tchk);
        got.delete();
        done_cnt = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (tchk) begin
            check("start_busy", busy, 1);
            check("start_hdr_rd", hdr_rd, 1);
            check("start_hdr_addr", hdr_addr, 0);
            check("start_out_valid", out_valid, 0);
        end
        for (int i = 0; i < pq.size() || (tchk && i < 2); i++) begin
            if (i < pq.size()) begin
                word_valid = 1'b1;
                word_data  = pq[i].w;
                word_last  = pq[i].last;
                word_bytes = pq[i].nb;
                mq.push_back(pq[i]);
            end else word_valid = 1'b0;
            @(posedge clk); #1;
            if (tchk && i == 0) check("t1_out_valid", out_valid, 0);
            if (tchk && i == 1) begin
                check("t2_out_valid", out_valid, 1);
                check("t2_first_hdr_byte", out_byte, 8'hFF);
            end
        end
        word_valid = 1'b0;
    endtask

    task automatic finish_frame(input string nm, input bit use_model);
        int cyc = 0;
        if (use_model) model_frame();
        else while (mq.size() > 0) begin
            word_t x;
            x = mq.pop_front();
            if (x.last) break;
        end
        while (done_cnt == 0 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({nm, "_done_seen"}, 32'(done_cnt > 0), 1);
        repeat (3) @(posedge clk);
        #1;
        check({nm, "_len"}, got.size(), eq.size());
        for (int i = 0; i < got.size() && i < eq.size(); i++)
            check($sformatf("%s_byte%0d", nm, i), got[i], eq[i]);
        check({nm, "_done_once"}, done_cnt, 1);
        check({nm, "_idle"}, busy, 0);
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, "_out_valid"}, out_valid, 0);
        check({nm, "_out_byte"}, out_byte, 0);
        check({nm, "_hdr_rd"}, hdr_rd, 0);
        check({nm, "_hdr_addr"}, hdr_addr, 0);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_done"}, done, 0);
        check({nm, "_overflow"}, overflow, 0);
    endtask

    typedef struct { logic [31:0] w; logic [1:0] nb; int rdy; int n; logic [63:0] e; } vec_t;
    vec_t tbl[6];

    initial begin
        word_t x;
        tbl[0] = '{32'h12345678, 2'd0, 0, 4, 64'h12345678_00000000};
        tbl[1] = '{32'hAAFFBBFF, 2'd0, 0, 6, 64'hAAFF00BB_FF000000};
        tbl[2] = '{32'hC1C2C3C4, 2'd2, 0, 2, 64'hC1C20000_00000000};
        tbl[3] = '{32'hFF123456, 2'd1, 1, 2, 64'hFF000000_00000000};
        tbl[4] = '{32'h00FF11FF, 2'd3, 1, 4, 64'h00FF0011_00000000};
        tbl[5] = '{32'hDEADBEEF, 2'd0, 1, 4, 64'hDEADBEEF_00000000};

        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        nrst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            pq.delete();
            x.w = tbl[i].w; x.last = 1'b1; x.nb = tbl[i].nb;
            pq.push_back(x);
            rdy_mode = tbl[i].rdy;
            begin_frame(i == 0);
            eq.delete();
            for (int k = 0; k < HDR_LEN; k++) eq.push_back(rom[k]);
            for (int k = 0; k < tbl[i].n; k++) eq.push_back(tbl[i].e[63-8*k -: 8]);
            eq.push_back(8'hFF);
            eq.push_back(8'hD9);
            finish_frame($sformatf("tbl%0d", i), 0);
        end

        // A second last word stays queued and forms the next frame.
        rdy_mode = 0;
        pq.delete();
        x.w = 32'h11223344; x.last = 1'b1; x.nb = 2'd0; pq.push_back(x);
        x.w = 32'h55FF6677; x.last = 1'b1; x.nb = 2'd2; pq.push_back(x);
        begin_frame(0);
        finish_frame("left_a", 1);
        pq.delete();
        begin_frame(0);
        finish_frame("left_b", 1);

        for (int f = 0; f < 8; f++) begin
            int nw;
            nw = $urandom_range(1, 6);
            pq.delete();
            for (int i = 0; i < nw; i++) begin
                x.w = 32'd0;
                for (int b = 0; b < 4; b++)
                    x.w = {x.w[23:0], ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom)};
                x.last = (i == nw - 1);
                x.nb = 2'($urandom_range(0, 3));
                pq.push_back(x);
            end
            rdy_mode = 1;
            begin_frame(0);
            finish_frame($sformatf("rnd%0d", f), 1);
        end

        // Overflow: header stalls behind out_ready=0 so nothing pops.
        rdy_mode = 2;
        @(posedge clk); #1;
        got.delete();
        done_cnt = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            x.w = $urandom; x.last = (i == 7); x.nb = 2'd0;
            word_valid = 1'b1; word_data = x.w; word_last = x.last; word_bytes = x.nb;
            if (i < FD) mq.push_back(x);
            @(posedge clk); #1;
        end
        word_valid = 1'b0;
        check("ovf_set", overflow, 1);
        rdy_mode = 0;
        finish_frame("ovf", 1);
        check("ovf_sticky", overflow, 1);
        pq.delete();
        x.w = 32'h01020304; x.last = 1'b1; x.nb = 2'd0; pq.push_back(x);
        begin_frame(0);
        check("ovf_cleared", overflow, 0);
        finish_frame("post_ovf", 1);

        // Reset in the middle of the scan section.
        pq.delete();
        for (int i = 0; i < 4; i++) begin
            x.w = $urandom; x.last = (i == 3); x.nb = 2'd0; pq.push_back(x);
        end
        begin_frame(0);
        begin
            int cyc = 0;
            while (got.size() < HDR_LEN + 2 && cyc < 500) begin
                @(posedge clk); #1;
                cyc++;
            end
            check("midscan_reached", 32'(got.size() >= HDR_LEN + 2), 1);
        end
        nrst = 1'b0;
        #1;
        check_reset_vals("midrst");
        mq.delete();
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        pq.delete();
        x.w = 32'hA1B2C3D4; x.last = 1'b1; x.nb = 2'd0; pq.push_back(x);
        begin_frame(1);
        finish_frame("after_rst", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
